// File: rtl/mux_pkg.sv
// Shared state encoding and default sizing for the N-way select pipeline stage.
package mux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NWAY  = 4;
    localparam int DEF_CNTW  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/mux_nway_sel.sv
// Purpose: combinational N-way WIDTH-bit selector with out-of-range flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage owns flow control.
module mux_nway_sel #(
    parameter int WIDTH = 32,
    parameter int NWAY  = 4,
    parameter int SELW  = $clog2(NWAY)
) (
    input  logic [NWAY*WIDTH-1:0] data_i,
    input  logic [SELW-1:0]       sel_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  sel_err_o
);

    // A select that matches no way leaves data at zero and keeps the error flag set.
    always_comb begin
        data_o    = '0;
        sel_err_o = 1'b1;
        for (int k = 0; k < NWAY; k++) begin
            if (sel_i == SELW'(k)) begin
                data_o    = data_i[k*WIDTH +: WIDTH];
                sel_err_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nway_pipe.sv
// Purpose: N-way select with registered output, 2-entry skid buffer and accepted-beat counter.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready (registered) drops the cycle after the skid entry fills.
module mux_nway_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NWAY  = DEF_NWAY,
    parameter int SELW  = $clog2(NWAY),
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       in_sel,
    input  logic [NWAY*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_sel_err,
    output logic [CNTW-1:0]       beat_count
);

    state_e            state_q;
    logic [WIDTH-1:0]  main_data_q, skid_data_q;
    logic [SELW-1:0]   main_sel_q, skid_sel_q;
    logic              main_err_q, skid_err_q;
    logic              out_valid_q, in_ready_q;
    logic [CNTW-1:0]   count_q;

    logic [WIDTH-1:0]  sel_data_d;
    logic              sel_err_d;
    logic              accept, drain;

    // Select is resolved at accept time so buffered entries hold final data.
    mux_nway_sel #(
        .WIDTH (WIDTH),
        .NWAY  (NWAY),
        .SELW  (SELW)
    ) u_sel (
        .data_i    (in_data),
        .sel_i     (in_sel),
        .data_o    (sel_data_d),
        .sel_err_o (sel_err_d)
    );

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            count_q     <= '0;
        end else if (flush) begin
            // Discards buffered beats and any beat offered this cycle; the counter is kept.
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (accept) begin
                count_q <= count_q + CNTW'(1);
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_q <= sel_data_d;
                        main_sel_q  <= in_sel;
                        main_err_q  <= sel_err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_data_q <= sel_data_d;
                        main_sel_q  <= in_sel;
                        main_err_q  <= sel_err_d;
                    end else if (accept) begin
                        skid_data_q <= sel_data_d;
                        skid_sel_q  <= in_sel;
                        skid_err_q  <= sel_err_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= ST_TWO;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_data_q <= skid_data_q;
                        main_sel_q  <= skid_sel_q;
                        main_err_q  <= skid_err_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = main_data_q;
    assign out_sel     = main_sel_q;
    assign out_sel_err = main_err_q;
    assign beat_count  = count_q;

endmodule

// File: tb/tb_mux_nway_pipe.sv
// Scoreboard bench: two instances, 4-way with a 4-bit counter and 3-way with a 16-bit counter.
module tb_mux_nway_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
        logic        e;
    } exp_t;

    logic         clk;
    logic         rst_n;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sel_err;
    logic [1:0]   a_in_sel, a_out_sel;
    logic [127:0] a_in_data;
    logic [31:0]  a_out_data;
    logic [3:0]   a_beat_count;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sel_err;
    logic [1:0]   b_in_sel, b_out_sel;
    logic [95:0]  b_in_data;
    logic [31:0]  b_out_data;
    logic [15:0]  b_beat_count;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mux_nway_pipe #(.WIDTH(32), .NWAY(4), .CNTW(4)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (a_flush),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_sel      (a_in_sel),
        .in_data     (a_in_data),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_data    (a_out_data),
        .out_sel     (a_out_sel),
        .out_sel_err (a_out_sel_err),
        .beat_count  (a_beat_count)
    );

    mux_nway_pipe #(.WIDTH(32), .NWAY(3), .CNTW(16)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (b_flush),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_sel      (b_in_sel),
        .in_data     (b_in_data),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_data    (b_out_data),
        .out_sel     (b_out_sel),
        .out_sel_err (b_out_sel_err),
        .beat_count  (b_beat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one beat, waits (bounded) for in_ready, and records the expected output.
    task automatic send(input bit on_b, input logic [1:0] sel, input logic [31:0] exp_d, input bit exp_e);
        int   tmo;
        logic rdy;
        exp_t ex;
        tmo = 0;
        ex  = '{d: exp_d, s: sel, e: exp_e};
        if (on_b) begin b_in_valid = 1'b1; b_in_sel = sel; end
        else      begin a_in_valid = 1'b1; a_in_sel = sel; end
        rdy = on_b ? b_in_ready : a_in_ready;
        while (!rdy && tmo < 40) begin
            @(posedge clk); #1;
            tmo++;
            rdy = on_b ? b_in_ready : a_in_ready;
        end
        if (!rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0, expected 1 within 40 cycles");
        end else if (on_b) sb_b.push_back(ex);
        else               sb_a.push_back(ex);
        @(posedge clk); #1;
        if (on_b) b_in_valid = 1'b0;
        else      a_in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (sb_a.size() == 0) chk("a_unexpected_beat", 64'(a_out_data), 64'hDEAD_0000);
            else begin
                exp_t e;
                e = sb_a.pop_front();
                chk("a_out_data", 64'(a_out_data), 64'(e.d));
                chk("a_out_sel", 64'(a_out_sel), 64'(e.s));
                chk("a_out_sel_err", 64'(a_out_sel_err), 64'(e.e));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (sb_b.size() == 0) chk("b_unexpected_beat", 64'(b_out_data), 64'hDEAD_0000);
            else begin
                exp_t e;
                e = sb_b.pop_front();
                chk("b_out_data", 64'(b_out_data), 64'(e.d));
                chk("b_out_sel", 64'(b_out_sel), 64'(e.s));
                chk("b_out_sel_err", 64'(b_out_sel_err), 64'(e.e));
            end
        end
    end

    initial begin
        int tmo;
        // Reset held low with random stimulus
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_flush = 1'($urandom); a_in_valid = 1'($urandom); a_in_sel = 2'($urandom);
            a_in_data = {$urandom, $urandom, $urandom, $urandom}; a_out_ready = 1'($urandom);
            b_flush = 1'($urandom); b_in_valid = 1'($urandom); b_in_sel = 2'($urandom);
            b_in_data = {$urandom, $urandom, $urandom}; b_out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        chk("rst_out_sel", 64'(a_out_sel), 64'd0);
        chk("rst_out_sel_err", 64'(a_out_sel_err), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_beat_count", 64'(a_beat_count), 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_sel = 2'd0; a_out_ready = 1'b1;
        a_in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_sel = 2'd0; b_out_ready = 1'b1;
        b_in_data = {32'hC2, 32'hB1, 32'hA0};
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming, one beat per cycle
        send(0, 2'd0, 32'h11, 0);
        chk("lat_out_valid", 64'(a_out_valid), 64'd1);
        chk("lat_out_data", 64'(a_out_data), 64'h11);
        send(0, 2'd1, 32'h22, 0);
        send(0, 2'd2, 32'h33, 0);
        send(0, 2'd3, 32'h44, 0);
        repeat (2) @(posedge clk); #1;
        chk("stream_beat_count", 64'(a_beat_count), 64'd4);
        chk("stream_sb_empty", 64'(sb_a.size()), 64'd0);

        // Out-of-range select on the 3-way instance
        send(1, 2'd3, 32'h0, 1);
        send(1, 2'd2, 32'hC2, 0);
        send(1, 2'd0, 32'hA0, 0);
        repeat (2) @(posedge clk); #1;
        chk("range_beat_count", 64'(b_beat_count), 64'd3);
        chk("range_sb_empty", 64'(sb_b.size()), 64'd0);

        // Backpressure: two beats buffered, third waits for release
        a_out_ready = 1'b0;
        send(0, 2'd3, 32'h44, 0);
        chk("bp_in_ready_one", 64'(a_in_ready), 64'd1);
        send(0, 2'd0, 32'h11, 0);
        chk("bp_in_ready_two", 64'(a_in_ready), 64'd0);
        fork
            send(0, 2'd2, 32'h33, 0);
            begin
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("bp_hold_data", 64'(a_out_data), 64'h44);
                    chk("bp_hold_in_ready", 64'(a_in_ready), 64'd0);
                end
                a_out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("bp_beat_count", 64'(a_beat_count), 64'd7);
        chk("bp_sb_empty", 64'(sb_a.size()), 64'd0);
        chk("bp_out_valid_idle", 64'(a_out_valid), 64'd0);

        // Flush from TWO with a beat offered
        a_out_ready = 1'b0;
        send(0, 2'd1, 32'h22, 0);
        send(0, 2'd2, 32'h33, 0);
        a_in_valid = 1'b1; a_in_sel = 2'd0; a_flush = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_flush = 1'b0;
        sb_a.delete();
        chk("flush2_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush2_in_ready", 64'(a_in_ready), 64'd1);
        chk("flush2_beat_count", 64'(a_beat_count), 64'd9);

        // Flush from ONE: the offered beat would be accepted but must be dropped
        send(0, 2'd3, 32'h44, 0);
        a_in_valid = 1'b1; a_in_sel = 2'd0; a_flush = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_flush = 1'b0;
        sb_a.delete();
        chk("flush1_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush1_beat_count", 64'(a_beat_count), 64'd10);
        a_out_ready = 1'b1;
        send(0, 2'd1, 32'h22, 0);
        repeat (2) @(posedge clk); #1;
        chk("postflush_beat_count", 64'(a_beat_count), 64'd11);

        // Asynchronous reset between edges with a beat held
        a_out_ready = 1'b0;
        send(0, 2'd2, 32'h33, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_out_data", 64'(a_out_data), 64'd0);
        chk("arst_in_ready", 64'(a_in_ready), 64'd1);
        chk("arst_beat_count", 64'(a_beat_count), 64'd0);
        chk("arst_b_beat_count", 64'(b_beat_count), 64'd0);
        sb_a.delete();
        sb_b.delete();
        rst_n = 1'b1;

        // Counter wrap: 17 beats on a 4-bit counter
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            send(0, 2'(i % 4), 32'h11 * 32'((i % 4) + 1), 0);
        end
        repeat (3) @(posedge clk); #1;
        chk("wrap_beat_count", 64'(a_beat_count), 64'd1);

        tmo = 0;
        while ((sb_a.size() != 0 || sb_b.size() != 0) && tmo < 50) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("final_sb_a_empty", 64'(sb_a.size()), 64'd0);
        chk("final_sb_b_empty", 64'(sb_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
